// File: rtl/core_run_ctrl_if.sv
// core_run_ctrl_if: host program-load handshake plus the instruction-memory write port
// driven by the run controller.
interface core_run_ctrl_if #(parameter int DATA_W = 32, parameter int AW = 9);
   logic              load_valid;
   logic              load_last;
   logic              load_ready;
   logic [DATA_W-1:0] load_data;
   logic              imem_we;
   logic [AW-1:0]     imem_waddr;
   logic [DATA_W-1:0] imem_wdata;
   modport master (output load_valid, load_data, load_last,
                   input  load_ready, imem_we, imem_waddr, imem_wdata);
   modport slave  (input  load_valid, load_data, load_last,
                   output load_ready, imem_we, imem_waddr, imem_wdata);
endinterface

// File: rtl/core_run_ctrl.sv
// core_run_ctrl: load/run sequencer for the single-cycle core; optional single-step gating
// is enabled by defining CORE_RUN_CTRL_STEP_EN.
module core_run_ctrl #(
   parameter int DATA_W     = 32,
   parameter int IMEM_DEPTH = 512,
   parameter int MAX_INSTR  = 0
) (
   input  logic              clk1,
   input  logic              reset1_n,
   input  logic              load_start,
   input  logic              run_start,
   input  logic              abort,
   input  logic [DATA_W-1:0] instr,
`ifdef CORE_RUN_CTRL_STEP_EN
   input  logic              step_mode,
   input  logic              step_req,
`endif
   core_run_ctrl_if.slave    lif,
   output logic              core_reset,
   output logic              pc_en,
   output logic              commit_en,
   output logic              busy,
   output logic              halted,
   output logic              timeout,
   output logic              load_err,
   output logic [31:0]       instr_count
);
   localparam int AW = $clog2(IMEM_DEPTH);
   localparam logic [2:0] IDLE = 3'd0, LOAD = 3'd1, PRIME = 3'd2, RUN = 3'd3, HALT = 3'd4;
   logic [2:0]    st, st_nx;
   logic [AW-1:0] cnt;
   logic [31:0]   cnt_nx;
   logic          xfer, ebreak, step_ok, commit, lim_hit, last_slot;
`ifdef CORE_RUN_CTRL_STEP_EN
   assign step_ok = !step_mode || step_req;
`else
   assign step_ok = 1'b1;
`endif
   assign xfer      = st == LOAD && lif.load_valid;
   assign last_slot = cnt == AW'(IMEM_DEPTH - 1);
   assign ebreak    = st == RUN && instr == DATA_W'(32'h00100073);
   assign commit    = st == RUN && !ebreak && step_ok;
   assign cnt_nx    = instr_count + 32'(instr_count != 32'hFFFF_FFFF);
   assign lim_hit   = MAX_INSTR != 0 && commit && cnt_nx == 32'(MAX_INSTR);
   assign lif.load_ready = st == LOAD;
   assign lif.imem_we    = xfer;
   assign lif.imem_waddr = cnt;
   assign lif.imem_wdata = lif.load_data;
   assign core_reset = st == IDLE || st == LOAD || st == PRIME;
   assign pc_en      = commit;
   assign commit_en  = commit;
   assign busy       = st == LOAD || st == PRIME || st == RUN;
   assign halted     = st == HALT;
   always_comb begin
      st_nx = st;
      case (st)
         IDLE, HALT: st_nx = load_start ? LOAD : run_start ? PRIME : st;
         LOAD:       st_nx = xfer && (lif.load_last || last_slot) ? IDLE : LOAD;
         PRIME:      st_nx = RUN;
         RUN:        st_nx = ebreak || lim_hit || abort ? HALT : RUN;
         default:    st_nx = IDLE;
      endcase
   end
   always_ff @(posedge clk1 or negedge reset1_n) begin
      if (!reset1_n) begin
         st          <= IDLE;
         cnt         <= '0;
         instr_count <= '0;
         timeout     <= 1'b0;
         load_err    <= 1'b0;
      end else begin
         st <= st_nx;
         if ((st == IDLE || st == HALT) && load_start) begin
            cnt      <= '0;
            load_err <= 1'b0;
         end else if (xfer) begin
            cnt      <= cnt + AW'(1);
            load_err <= !lif.load_last && last_slot;
         end
         if (st == PRIME) begin
            instr_count <= '0;
            timeout     <= 1'b0;
         end else if (commit) begin
            instr_count <= cnt_nx;
         end
         if (lim_hit) timeout <= 1'b1;
      end
   end
endmodule

// File: tb/tb_core_run_ctrl.sv
// tb_core_run_ctrl: scoreboard bench for core_run_ctrl; a second instance with MAX_INSTR=3
// covers the run-limit path.
module tb_core_run_ctrl;
   localparam logic [31:0] EBREAK = 32'h00100073, NOP = 32'h00000013;
   logic        clk1 = 1'b0, reset1_n = 1'b0;
   logic        load_start = 1'b0, run_start = 1'b0, abort = 1'b0, run_start2 = 1'b0;
   logic [31:0] instr, instr_count, instr_count2;
   logic        core_reset, pc_en, commit_en, busy, halted, timeout, load_err;
   logic        core_reset2, pc_en2, commit_en2, busy2, halted2, timeout2, load_err2;
`ifdef CORE_RUN_CTRL_STEP_EN
   logic        step_mode = 1'b0, step_req = 1'b0;
`endif
   logic [31:0] prog [16];
   logic [3:0]  pc = '0;
   logic [40:0] sb [$];
   int          n_chk = 0, n_err = 0, n_we = 0, n0;
   core_run_ctrl_if #(.DATA_W(32), .AW(9)) lif (), lif2 ();
   core_run_ctrl dut (
      .clk1(clk1), .reset1_n(reset1_n), .load_start(load_start), .run_start(run_start),
      .abort(abort), .instr(instr),
`ifdef CORE_RUN_CTRL_STEP_EN
      .step_mode(step_mode), .step_req(step_req),
`endif
      .lif(lif), .core_reset(core_reset), .pc_en(pc_en), .commit_en(commit_en), .busy(busy),
      .halted(halted), .timeout(timeout), .load_err(load_err), .instr_count(instr_count));
   core_run_ctrl #(.MAX_INSTR(3)) dut2 (
      .clk1(clk1), .reset1_n(reset1_n), .load_start(1'b0), .run_start(run_start2),
      .abort(1'b0), .instr(NOP),
`ifdef CORE_RUN_CTRL_STEP_EN
      .step_mode(1'b0), .step_req(1'b0),
`endif
      .lif(lif2), .core_reset(core_reset2), .pc_en(pc_en2), .commit_en(commit_en2), .busy(busy2),
      .halted(halted2), .timeout(timeout2), .load_err(load_err2), .instr_count(instr_count2));
   always #5 clk1 = ~clk1;
   always @(posedge clk1) pc <= core_reset ? 4'd0 : pc + 4'(pc_en);
   assign instr = prog[pc];
   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk1);
      #1;
   endtask
   task automatic send(input logic [31:0] d, input logic last, input logic [8:0] a);
      lif.load_valid = 1'b1;
      lif.load_data  = d;
      lif.load_last  = last;
      sb.push_back({a, d});
      tick();
      lif.load_valid = 1'b0;
      lif.load_last  = 1'b0;
   endtask
   always @(negedge clk1) begin
      logic [40:0] e;
      if (lif.imem_we || sb.size() != 0) begin
         chk("imem_we", 64'(lif.imem_we), 64'(sb.size() != 0));
         if (lif.imem_we) n_we++;
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("imem_waddr", 64'(lif.imem_waddr), 64'(e[40:32]));
            chk("imem_wdata", 64'(lif.imem_wdata), 64'(e[31:0]));
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   initial begin
      for (int i = 0; i < 16; i++) prog[i] = NOP | (32'(i) << 20);
      prog[5] = EBREAK;
      lif.load_valid = 1'b0; lif.load_last = 1'b0; lif.load_data = '0;
      lif2.load_valid = 1'b0; lif2.load_last = 1'b0; lif2.load_data = '0;
      #3;
      chk("rst_core_reset", core_reset, 1);
      chk("rst_busy", busy, 0);
      chk("rst_halted", halted, 0);
      chk("rst_load_ready", lif.load_ready, 0);
      chk("rst_pc_en", pc_en, 0);
      chk("rst_count", instr_count, 0);
      chk("rst_timeout", timeout, 0);
      chk("rst_load_err", load_err, 0);
      repeat (2) tick();
      reset1_n = 1'b1;
      tick();
      load_start = 1'b1; tick(); load_start = 1'b0;
      chk("load_ready", lif.load_ready, 1);
      for (int w = 0; w < 3; w++) send(32'h00418000 + 32'(w), 1'b0, 9'(w));
      reset1_n = 1'b0;
      #1;
      chk("midrst_core_reset", core_reset, 1);
      chk("midrst_load_ready", lif.load_ready, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_count", instr_count, 0);
      tick(); reset1_n = 1'b1; tick();
      n0 = n_we;
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int w = 0; w < 4; w++) begin
         send(32'h00418093 | (32'(w) << 20), w == 3, 9'(w));
         if (w < 3) tick();
      end
      chk("load4_writes", 64'(n_we - n0), 4);
      chk("load4_ready", lif.load_ready, 0);
      chk("load4_busy", busy, 0);
      chk("load4_err", load_err, 0);
      n0 = n_we;
      load_start = 1'b1; tick(); load_start = 1'b0;
      for (int w = 0; w < 512; w++) send(32'hA5A50000 ^ 32'(w), 1'b0, 9'(w));
      chk("ovf_err", load_err, 1);
      chk("ovf_busy", busy, 0);
      lif.load_valid = 1'b1; lif.load_data = 32'hDEADBEEF;
      chk("ovf_ready", lif.load_ready, 0);
      chk("ovf_we", lif.imem_we, 0);
      tick();
      lif.load_valid = 1'b0;
      chk("ovf_writes", 64'(n_we - n0), 512);
      run_start = 1'b1; tick(); run_start = 1'b0;
      chk("prime_busy", busy, 1);
      chk("prime_core_reset", core_reset, 1);
      chk("prime_pc_en", pc_en, 0);
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("run_pc_en", pc_en, 1);
         chk("run_commit_en", commit_en, 1);
         chk("run_core_reset", core_reset, 0);
         tick();
      end
      chk("ebreak_pc_en", pc_en, 0);
      chk("ebreak_commit_en", commit_en, 0);
      chk("ebreak_busy", busy, 1);
      tick();
      chk("halt_halted", halted, 1);
      chk("halt_busy", busy, 0);
      chk("halt_count", instr_count, 5);
      chk("halt_timeout", timeout, 0);
      chk("halt_pc_en", pc_en, 0);
      tick();
      chk("halt_hold_count", instr_count, 5);
      run_start = 1'b1; tick(); run_start = 1'b0;
      tick();
      repeat (2) tick();
      abort = 1'b1;
      chk("abort_pc_en", pc_en, 1);
      tick();
      abort = 1'b0;
      chk("abort_halted", halted, 1);
      chk("abort_count", instr_count, 3);
      load_start = 1'b1; run_start = 1'b1; tick(); load_start = 1'b0; run_start = 1'b0;
      chk("both_load_ready", lif.load_ready, 1);
      chk("both_busy", busy, 1);
      chk("both_halted", halted, 0);
      send(NOP, 1'b1, 9'd0);
      chk("both_done_busy", busy, 0);
`ifdef CORE_RUN_CTRL_STEP_EN
      step_mode = 1'b1;
      run_start = 1'b1; tick(); run_start = 1'b0;
      tick();
      for (int k = 0; k < 3; k++) begin
         step_req = 1'b0;
         chk("step_idle_pc_en", pc_en, 0);
         tick();
         step_req = 1'b1;
         chk("step_pc_en", pc_en, 1);
         tick();
         step_req = 1'b0;
      end
      chk("step_count", instr_count, 3);
      abort = 1'b1; tick(); abort = 1'b0;
      chk("step_abort_halted", halted, 1);
      chk("step_abort_count", instr_count, 3);
      step_mode = 1'b0;
`endif
      run_start2 = 1'b1; tick(); run_start2 = 1'b0;
      tick();
      chk("lim_pc_en", pc_en2, 1);
      repeat (2) tick();
      chk("lim_not_yet", halted2, 0);
      tick();
      chk("lim_halted", halted2, 1);
      chk("lim_timeout", timeout2, 1);
      chk("lim_count", instr_count2, 3);
      run_start2 = 1'b1; tick(); run_start2 = 1'b0;
      tick();
      chk("lim_rerun_timeout", timeout2, 0);
      chk("lim_rerun_count", instr_count2, 0);
      repeat (3) tick();
      chk("lim2_halted", halted2, 1);
      chk("lim2_count", instr_count2, 3);
      chk("sb_empty", 64'(sb.size()), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/core_run_ctrl.md
Name: core_run_ctrl

Overview:
- Run/load sequencer for the single-cycle RISC-V core.
- Streams a program from a host into instruction memory through a valid/ready handshake.
- Holds the core in reset while loading, then releases it and gates PC advance and architectural writes (regfile and data memory).
- Stops the core on EBREAK, on an instruction-count limit, or on host abort; leaves the core state intact for inspection.

Parameters:
- DATA_W, 32, instruction/load word width
- IMEM_DEPTH, 512, instruction memory words; imem write address width AW = $clog2(IMEM_DEPTH)
- MAX_INSTR, 0, run limit in executed instructions; 0 = unlimited

Ports:
- clk1  in  1  system clock
- reset1_n  in  1  asynchronous active-low reset
- load_start  in  1  pulse: enter LOAD
- run_start  in  1  pulse: start execution from PC=0
- abort  in  1  level: stop RUN at the next clock
- load_valid  in  1  host word valid
- load_data  in  DATA_W  host program word
- load_last  in  1  marks final word, qualified by load_valid
- load_ready  out  1  block accepts a word
- instr  in  DATA_W  instruction currently fetched by the core
- imem_we  out  1  instruction memory write strobe
- imem_waddr  out  AW  instruction memory write address
- imem_wdata  out  DATA_W  instruction memory write data
- core_reset  out  1  active-high reset to the core PC
- pc_en  out  1  PC increment enable
- commit_en  out  1  gates regfile write_back_en and dmem wr_en
- busy  out  1  state is LOAD, PRIME or RUN
- halted  out  1  state is HALT
- timeout  out  1  last run ended on MAX_INSTR
- load_err  out  1  load overflowed IMEM_DEPTH
- instr_count  out  32  instructions committed in the current/last run

Behaviour:
- Reset (async, reset1_n=0): state IDLE, load count 0, instr_count 0, core_reset=1, all other outputs 0.
- States: IDLE, LOAD, PRIME, RUN, HALT. Outputs are Moore from state, except imem_we, the EBREAK gating and the STEP_EN gating, which are combinational.
- IDLE:
  - core_reset=1.
  - load_start -> LOAD, clearing the load count and load_err.
  - else run_start -> PRIME.
  - If both are asserted in the same cycle, load_start wins.
- LOAD:
  - load_ready=1, core_reset=1.
  - A transfer occurs when load_valid && load_ready. In that same cycle: imem_we=1, imem_waddr=count, imem_wdata=load_data. Count increments at the clock.
  - Transfer with load_last -> IDLE.
  - Transfer at count==IMEM_DEPTH-1 without load_last: the word is written, load_err=1, -> IDLE.
  - run_start and abort are ignored.
- PRIME:
  - Lasts exactly 1 cycle.
  - core_reset=1 clears the PC; instr_count and timeout are cleared; -> RUN.
- RUN:
  - core_reset=0, pc_en=1, commit_en=1.
  - instr_count increments on every committed cycle and saturates at 2^32-1.
  - instr==32'h00100073 (EBREAK): pc_en=0 and commit_en=0 combinationally in that cycle; not counted; -> HALT.
  - MAX_INSTR!=0 and the commit makes instr_count reach MAX_INSTR: that instruction commits, timeout=1, -> HALT.
  - abort=1: the current cycle still commits, -> HALT.
  - If EBREAK and abort occur in the same cycle, EBREAK gating applies.
- HALT:
  - halted=1, core_reset=0, pc_en=0, commit_en=0. PC, regfile and dmem are preserved.
  - load_start -> LOAD (priority); else run_start -> PRIME.
- Asynchronous reset in any state returns to IDLE. A partially loaded program remains in imem; the bench must not rely on its contents.
- busy and halted are never both 1.

Optional Feature:
- Macro CORE_RUN_CTRL_STEP_EN.
- When defined, adds input ports step_mode (1) and step_req (1).
  - In RUN with step_mode=1, pc_en and commit_en are asserted, and instr_count advances, only in cycles where step_req=1.
  - EBREAK, MAX_INSTR and abort behave as above. abort is honoured even when step_req=0.
  - With step_mode=0, RUN behaves free-running.
- When not defined, the ports are absent and RUN is always free-running.

Test Plan:
- Reset mid-LOAD after 3 words -> state IDLE, core_reset=1, load_ready=0, busy=0, instr_count=0.
- Load 4 words 0x00418..., last on the 4th, with load_valid toggled every other cycle -> exactly 4 imem_we pulses at addr 0,1,2,3; data matches; no write while load_valid=0; return to IDLE; load_err=0.
- Load IMEM_DEPTH+1 words with no load_last -> writes at addr 0..511, then load_err=1 and IDLE; the 513th word is not accepted (load_ready=0).
- Program of 5 ALU ops then EBREAK, run_start -> PRIME for 1 cycle, RUN for 6 cycles, pc_en=0 and commit_en=0 on the EBREAK cycle, halted=1, instr_count=5.
- MAX_INSTR=3 on a 10-instruction program -> HALT after 3 commits, timeout=1, instr_count=3. A second run_start clears timeout.
- load_start and run_start asserted together in HALT -> LOAD entered. abort during RUN -> HALT on the next edge with the current cycle committed. With STEP_EN, 3 step_req pulses -> instr_count=3.
